note_sequencer: RTL

//   Song playback controller feeding the PWM modulator in the tinytone audio path. Replaces fixed-rate note stepping

---
 rtl/note_sequencer_pkg.sv | 15 +
 rtl/note_sequencer_tick_timer.sv | 42 ++++
 rtl/note_sequencer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/note_sequencer_pkg.sv
// Shared types and defaults for the tinytone note sequencer: FSM state encoding and
// default tick/gap timing.
package note_sequencer_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StPlay,
        StDone
    } seq_state_e;

    localparam int unsigned DefTickPeriod = 600000;
    localparam int unsigned DefGapCycles  = 48000;

endpackage

// File: rtl/note_sequencer_tick_timer.sv
// Duration tick counter: counts 0..PERIOD-1 while enabled, pulses wrap_o on the last count,
// and flags when the upcoming count falls within the final LAST_N cycles of a period.
module note_sequencer_tick_timer #(
    parameter int unsigned CNT_BW = 24,
    parameter int unsigned PERIOD = 600000,
    parameter int unsigned LAST_N = 48000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic clr_i,
    output logic wrap_o,
    output logic last_n_next_o
);

    localparam logic [CNT_BW-1:0] TopVal   = CNT_BW'(PERIOD - 1);
    localparam logic [CNT_BW-1:0] GapStart = CNT_BW'(PERIOD - LAST_N);

    logic [CNT_BW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        wrap_o  = en_i && (count_q == TopVal);
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = wrap_o ? '0 : count_q + CNT_BW'(1);
        end
    end

    // Looks at the next count so the registered gate lines up with the cycle it covers.
    assign last_n_next_o = (LAST_N != 0) && (count_d >= GapStart);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/note_sequencer.sv
// Song playback controller: walks the notes ROM, applies per-note durations, rests and an
// articulation gap, and presents the PWM period plus a sound gate.
module note_sequencer
    import note_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_BW     = 6,
    parameter int unsigned SEQ_LEN     = 64,
    parameter int unsigned DIV_BW      = 16,
    parameter int unsigned DUR_BW      = 4,
    parameter int unsigned TICK_BW     = 24,
    parameter int unsigned TICK_PERIOD = DefTickPeriod,
    parameter int unsigned GAP_CYCLES  = DefGapCycles
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               play_i,
    input  logic               restart_i,
    input  logic               loop_i,
    output logic [ADDR_BW-1:0] romAddr_o,
    input  logic [DIV_BW-1:0]  romDivider_i,
    input  logic [DUR_BW-1:0]  romDuration_i,
    output logic [DIV_BW-1:0]  period_o,
    output logic               gate_o,
    output logic               noteStrb_o,
    output logic               done_o
);

    localparam logic [DUR_BW:0]    RemOne   = (DUR_BW + 1)'(1);
    localparam logic [ADDR_BW-1:0] LastAddr = ADDR_BW'(SEQ_LEN - 1);

    seq_state_e         state_q, state_d;
    logic [ADDR_BW-1:0] addr_q, addr_d;
    logic [DIV_BW-1:0]  period_q, period_d;
    logic [DUR_BW:0]    rem_q, rem_d;
    logic               gate_q, gate_d;
    logic               strb_q, strb_d;
    logic               done_q, done_d;
    logic               tick_en, tick_clr, tick_wrap, gap_next, end_marker;

    assign end_marker = (romDivider_i == '0) && (&romDuration_i);
    assign tick_en    = play_i && (state_q == StPlay);
    assign tick_clr   = restart_i || (state_q != StPlay);

    note_sequencer_tick_timer #(
        .CNT_BW (TICK_BW),
        .PERIOD (TICK_PERIOD),
        .LAST_N (GAP_CYCLES)
    ) u_tick_timer (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .en_i          (tick_en),
        .clr_i         (tick_clr),
        .wrap_o        (tick_wrap),
        .last_n_next_o (gap_next)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        period_d = period_q;
        rem_d    = rem_q;
        strb_d   = 1'b0;
        if (restart_i) begin
            state_d = play_i ? StLoad : StIdle;
            addr_d  = '0;
            rem_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: if (play_i) state_d = StLoad;
                StLoad: begin
                    if (end_marker) begin
                        if (loop_i) addr_d = '0;
                        else        state_d = StDone;
                    end else begin
                        period_d = romDivider_i;
                        rem_d    = {1'b0, romDuration_i} + RemOne;
                        strb_d   = 1'b1;
                        state_d  = StPlay;
                    end
                end
                StPlay: begin
                    if (tick_wrap) begin
                        if (rem_q == RemOne) begin
                            rem_d = '0;
                            if (addr_q != LastAddr) begin
                                addr_d  = addr_q + ADDR_BW'(1);
                                state_d = StLoad;
                            end else if (loop_i) begin
                                addr_d  = '0;
                                state_d = StLoad;
                            end else begin
                                state_d = StDone;
                            end
                        end else begin
                            rem_d = rem_q - RemOne;
                        end
                    end
                end
                StDone: ;
                default: state_d = StIdle;
            endcase
        end
        done_d = (state_d == StDone);
        // Gate describes the upcoming cycle: silent for rests, pauses and the closing gap.
        gate_d = (state_d == StPlay) && (period_d != '0) && play_i &&
                 !((rem_d == RemOne) && gap_next);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            period_q <= '0;
            rem_q    <= '0;
            gate_q   <= 1'b0;
            strb_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            period_q <= period_d;
            rem_q    <= rem_d;
            gate_q   <= gate_d;
            strb_q   <= strb_d;
            done_q   <= done_d;
        end
    end

    assign romAddr_o  = addr_q;
    assign period_o   = period_q;
    assign gate_o     = gate_q;
    assign noteStrb_o = strb_q;
    assign done_o     = done_q;

endmodule
